mc_edge_logger: RTL
===================

// Module: mc_edge_logger
// PURPOSE
//  - Downstream of the multichannel output stage: watches the 32-bit physical output word (post switch matrix).
//  - Logs every masked change as a timestamped snapshot into a show-ahead FIFO.
//  - Host software reads back the snapshots through the BUS read path to verify output sequences.
// PARAMETERS
//  WIDTH       32  monitored output width (matches the output port count)
//  TS_W        24  timestamp width, in io_clk cycles
//  DEPTH_LOG2  4   FIFO depth = 2**DEPTH_LOG2 entries
// PORTS
//  io_clk       in   1              system clock
//  io_rst       in   1              async reset, active-high
//  io_en        in   1              logging enable (arm)
//  io_clear     in   1              sync clear: empties FIFO, zeroes timestamp, clears overflow and drop count
//  io_sig       in   WIDTH          monitored outputs (synchronous to io_clk)
//  io_mask      in   WIDTH          1 = channel participates in change detection
//  io_rd_en     in   1              pop the head entry
//  io_rd_valid  out  1              head entry valid (= ~io_empty)
//  io_rd_data   out  TS_W+WIDTH     head entry = {timestamp, sig snapshot}
//  io_count     out  DEPTH_LOG2+1   entries held, 0 .. 2**DEPTH_LOG2
//  io_empty     out  1              FIFO empty
//  io_full      out  1              FIFO full
//  io_overflow  out  1              sticky: at least one event was dropped
//  io_drop_cnt  out  16             dropped-event counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, io_rst=1):
//    - sig_q, ts, pointers, count, overflow and drop_cnt all go to 0.
//    - io_empty=1; io_full=0; io_rd_valid=0; io_rd_data=0.
//  - sig_q <= io_sig every cycle, independent of io_en.
//  - change = (io_sig ^ sig_q) & io_mask.
//  - Timestamp:
//    - ts increments by 1 per cycle while io_en=1 and holds while io_en=0.
//    - Wraps from 2**TS_W-1 to 0; no wrap marker is logged.
//    - ts is zeroed on the rising edge of io_en, so the first cycle of enable has ts=0.
//  - Push: push_req = io_en & (|change).
//    - Writes {ts, io_sig} at the same clock edge.
//    - The entry is visible on io_rd_data on the next cycle when the FIFO was empty (1-cycle latency).
//  - Baseline: io_en rising uses the previous-cycle sig_q, so a change coincident with enable is logged.
//  - Pop: io_rd_en & ~io_empty advances the read pointer. io_rd_en while empty is ignored (no underflow, no flag).
//  - Show-ahead read:
//    - io_rd_data is always the oldest entry.
//    - It is combinational from RAM plus read pointer and changes the cycle after a pop.
//  - Push while full:
//    - Without a pop in the same cycle: entry dropped, overflow <= 1, drop_cnt increments.
//    - With a pop in the same cycle: the push is accepted, count stays full, nothing is dropped.
//  - Push and pop together when not empty or full: count unchanged, both pointers advance.
//  - Push and pop together when empty: push accepted, pop ignored, count becomes 1.
//  - Pointers are DEPTH_LOG2 bits wide and wrap naturally. Full/empty come from io_count.
//  - io_clear:
//    - Has priority over push and pop in the same cycle; the event in that cycle is discarded.
//    - sig_q still updates, so no spurious event follows the clear.
//  - Async reset mid-operation abandons all entries; there is no partial-read state.
//  - io_mask changes take effect immediately. A masked-off channel's toggles never trigger a push, but its value still appears in snapshots.
// CONFIGURATION
//  - MC_LOG_DROPCNT_EN defined:
//    - io_drop_cnt is a 16-bit counter, +1 per dropped event.
//    - Saturates at 16'hFFFF; cleared by io_rst or io_clear.
//  - MC_LOG_DROPCNT_EN undefined:
//    - No counter logic; io_drop_cnt tied to 16'h0.
//    - io_overflow behaviour is identical in both builds.
// TESTING
//  - Reset check: io_rst pulse -> io_empty=1, io_count=0, io_overflow=0, io_rd_data=0, io_drop_cnt=0.
//  - Single event:
//    - Stimulus: mask=FFFFFFFF, en rises at cycle 0, io_sig 0->00000001 at cycle 5.
//    - Response: next cycle io_rd_valid=1, io_rd_data={24'd5, 32'h00000001}, io_count=1.
//  - Mask filtering: mask=0000000F; toggle io_sig bit 8, then bit 2 -> exactly 1 entry, snapshot includes bit 8's state.
//  - Overflow (DEPTH_LOG2=4):
//    - Stimulus: 20 distinct changes with no reads.
//    - Response: io_count=16, io_full=1, io_overflow=1; io_drop_cnt=4 (0 without the macro).
//    - Reading out returns the first 16 snapshots in order.
//  - Full with simultaneous push+pop: io_count stays 16, no drop, head advances by one entry.
//  - Clear/wrap:
//    - io_clear together with an event -> count=0 next cycle, event discarded.
//    - Run en for 2**24 cycles -> ts wraps; next logged timestamp is small (wrapped value).

Source files
------------

// File: rtl/mc_edge_logger.sv
// mc_edge_logger
//   Watches the physical output word and logs every masked change as a
//   {timestamp, snapshot} entry into a show-ahead FIFO for host readback.
//
//   Optional feature macro: MC_LOG_DROPCNT_EN
//     defined   -> io_drop_cnt is a saturating 16-bit dropped-event counter
//     undefined -> io_drop_cnt is tied to zero (io_overflow unaffected)
//
// Ports
//   io_clk       system clock
//   io_rst       asynchronous reset, active-high
//   io_en        logging enable (arm)
//   io_clear     synchronous clear of FIFO, timestamp, overflow, drop count
//   io_sig       monitored outputs
//   io_mask      1 = channel participates in change detection
//   io_rd_en     pop the head entry
//   io_rd_valid  head entry valid
//   io_rd_data   head entry {timestamp, snapshot}, zero when empty
//   io_count     entries held
//   io_empty     FIFO empty
//   io_full      FIFO full
//   io_overflow  sticky: at least one event dropped
//   io_drop_cnt  dropped-event counter
module mc_edge_logger #(
  parameter int WIDTH      = 32,
  parameter int TS_W       = 24,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                     io_clk,
  input  logic                     io_rst,
  input  logic                     io_en,
  input  logic                     io_clear,
  input  logic [WIDTH-1:0]         io_sig,
  input  logic [WIDTH-1:0]         io_mask,
  input  logic                     io_rd_en,
  output logic                     io_rd_valid,
  output logic [TS_W+WIDTH-1:0]    io_rd_data,
  output logic [DEPTH_LOG2:0]      io_count,
  output logic                     io_empty,
  output logic                     io_full,
  output logic                     io_overflow,
  output logic [15:0]              io_drop_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int EW    = TS_W + WIDTH;

  logic [WIDTH-1:0]      sig_q;
  logic                  en_q;
  logic [TS_W-1:0]       ts_q, ts_d, ts_cur;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [EW-1:0]         mem_q [DEPTH];

  logic [WIDTH-1:0]      change;
  logic                  push_req, push_ok, pop_ok, drop, empty, full;

  always_comb begin
    change   = (io_sig ^ sig_q) & io_mask;
    // The first enabled cycle always stamps zero, regardless of held ts_q.
    ts_cur   = (io_en & ~en_q) ? '0 : ts_q;
    push_req = io_en & (|change);
    empty    = (count_q == '0);
    // count never exceeds DEPTH, so its MSB alone marks full.
    full     = count_q[DEPTH_LOG2];
    pop_ok   = io_rd_en & ~empty & ~io_clear;
    // A pop in the same cycle frees the slot a full FIFO needs.
    push_ok  = push_req & (~full | (io_rd_en & ~empty)) & ~io_clear;
    drop     = push_req & full & ~io_rd_en & ~io_clear;

    ts_d     = ts_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (io_clear) begin
      ts_d     = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (io_en) ts_d = ts_cur + 1'b1;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      sig_q    <= '0;
      en_q     <= 1'b0;
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      // Baseline tracks io_sig even while disarmed or clearing.
      sig_q    <= io_sig;
      en_q     <= io_en;
      ts_q     <= ts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage carries data only; validity is tracked by count_q.
  always_ff @(posedge io_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {ts_cur, io_sig};
  end

`ifdef MC_LOG_DROPCNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      drop_cnt_q <= '0;
    end else if (io_clear) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign io_drop_cnt = drop_cnt_q;
`else
  assign io_drop_cnt = 16'h0;
`endif

  assign io_rd_valid = ~empty;
  assign io_rd_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign io_count    = count_q;
  assign io_empty    = empty;
  assign io_full     = full;
  assign io_overflow = ovf_q;

endmodule
